hs_deserializer: RTL and testbench

HS_DESERIALIZER -- requirements
Module: hs_deserializer

---
 rtl/hs_deserializer.sv | 120 ++++++++++++
 tb/tb_hs_deserializer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_deserializer.sv
// rtl/hs_deserializer.sv - packs DATA_WIDTH-bit items into ITEMS-wide words with a valid mask
//
// Purpose: collects input items into slots 0..ITEMS-1 of an output word. A word closes
// when its last slot is filled or din_last is seen. The closed word is then held on
// dout_* until the consumer takes it.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   din_data   - input item (DATA_WIDTH bits)
//   din_last   - input item is the final item of a packet
//   din_vld    - input item valid
//   din_rd     - ready to accept an input item
//   dout_data  - assembled word; item 0 in the low DATA_WIDTH bits
//   dout_mask  - per-slot valid bits
//   dout_last  - held word closes a packet
//   dout_vld   - output word valid
//   dout_rd    - consumer ready
module hs_deserializer #(
    parameter int DATA_WIDTH = 2,
    parameter int ITEMS      = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_WIDTH-1:0]       din_data,
    input  logic                        din_last,
    input  logic                        din_vld,
    output logic                        din_rd,
    output logic [ITEMS*DATA_WIDTH-1:0] dout_data,
    output logic [ITEMS-1:0]            dout_mask,
    output logic                        dout_last,
    output logic                        dout_vld,
    input  logic                        dout_rd
);

    localparam int IDX_W = (ITEMS > 1) ? $clog2(ITEMS) : 1;

    generate
        if (ITEMS < 2 || DATA_WIDTH < 1) begin : g_param_err
            $error("hs_deserializer: ITEMS must be >= 2 and DATA_WIDTH >= 1");
        end
    endgenerate

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t                      state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [ITEMS*DATA_WIDTH-1:0] data_q, data_d;
    logic [ITEMS-1:0]            mask_q, mask_d;
    logic                        last_q, last_d;
    logic [IDX_W-1:0]            slot;
    logic                        in_xfer;
    logic                        out_xfer;

    // Ready does not look at din_vld; in HOLD it follows dout_rd so the next word's
    // first item can enter on the edge the held word leaves.
    assign din_rd   = rst_n & ((state_q == COLLECT) | dout_rd);
    assign dout_vld = (state_q == HOLD);
    assign in_xfer  = din_vld & din_rd;
    assign out_xfer = dout_vld & dout_rd;

    assign dout_data = data_q;
    assign dout_mask = mask_q;
    assign dout_last = last_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        mask_d  = mask_q;
        last_d  = last_q;
        slot    = idx_q;

        // A departing word empties every slot before any new item is written.
        if (out_xfer) begin
            state_d = COLLECT;
            idx_d   = '0;
            data_d  = '0;
            mask_d  = '0;
            last_d  = 1'b0;
            slot    = '0;
        end

        if (in_xfer) begin
            for (int i = 0; i < ITEMS; i++) begin
                if (slot == IDX_W'(i)) begin
                    data_d[i*DATA_WIDTH +: DATA_WIDTH] = din_data;
                    mask_d[i]                          = 1'b1;
                end
            end
            if (slot == IDX_W'(ITEMS - 1) || din_last) begin
                state_d = HOLD;
                last_d  = din_last;
                idx_d   = '0;
            end else begin
                idx_d = slot + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            idx_q   <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_hs_deserializer.sv
// tb/tb_hs_deserializer.sv - self-checking bench for hs_deserializer
module tb_hs_deserializer;

    logic       clk;
    logic       rst_n;
    logic [1:0] din_data;
    logic       din_last;
    logic       din_vld;
    logic       din_rd;
    logic [7:0] dout_data;
    logic [3:0] dout_mask;
    logic       dout_last;
    logic       dout_vld;
    logic       dout_rd;

    logic [2:0] p_din_data;
    logic       p_din_last;
    logic       p_din_vld;
    logic       p_din_rd;
    logic [5:0] p_dout_data;
    logic [1:0] p_dout_mask;
    logic       p_dout_last;
    logic       p_dout_vld;
    logic       p_dout_rd;

    int tests = 0;
    int fails = 0;
    int words_out = 0;

    hs_deserializer u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din_data  (din_data),
        .din_last  (din_last),
        .din_vld   (din_vld),
        .din_rd    (din_rd),
        .dout_data (dout_data),
        .dout_mask (dout_mask),
        .dout_last (dout_last),
        .dout_vld  (dout_vld),
        .dout_rd   (dout_rd)
    );

    hs_deserializer #(.DATA_WIDTH(3), .ITEMS(2)) u_p (
        .clk       (clk),
        .rst_n     (rst_n),
        .din_data  (p_din_data),
        .din_last  (p_din_last),
        .din_vld   (p_din_vld),
        .din_rd    (p_din_rd),
        .dout_data (p_dout_data),
        .dout_mask (p_dout_mask),
        .dout_last (p_dout_last),
        .dout_vld  (p_dout_vld),
        .dout_rd   (p_dout_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a word is just the list of items received so far; closed
    // words wait in a queue whose head is what the consumer should see.
    typedef struct {
        logic [7:0] data;
        logic [3:0] mask;
        logic       last;
    } word_t;

    word_t held_q[$];
    int    items[$];

    function automatic word_t build(input logic l);
        word_t w;
        w.data = '0;
        for (int i = 0; i < items.size(); i++)
            w.data = w.data | (8'(items[i]) << (2 * i));
        w.mask = 4'((1 << items.size()) - 1);
        w.last = l;
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs and compare outputs with the model (called at posedge+1).
    task automatic drive(input logic v, input logic [1:0] d, input logic l, input logic r);
        word_t e;
        logic  held;
        din_vld = v; din_data = d; din_last = l; dout_rd = r;
        #1;
        held = (held_q.size() != 0);
        if (held) e = held_q[0];
        else      e = build(1'b0);
        chk("model_dout_vld",  32'(dout_vld),  32'(held));
        chk("model_din_rd",    32'(din_rd),    32'(!held || r));
        chk("model_dout_data", 32'(dout_data), 32'(e.data));
        chk("model_dout_mask", 32'(dout_mask), 32'(e.mask));
        chk("model_dout_last", 32'(dout_last), 32'(e.last));
    endtask

    task automatic advance();
        logic out_x, in_x;
        out_x = (held_q.size() != 0) && dout_rd;
        in_x  = din_vld && ((held_q.size() == 0) || dout_rd);
        @(posedge clk);
        if (out_x) begin
            void'(held_q.pop_front());
            words_out++;
        end
        if (in_x) begin
            items.push_back(int'(din_data));
            if (items.size() == 4 || din_last) begin
                held_q.push_back(build(din_last));
                items.delete();
            end
        end
        #1;
    endtask

    task automatic cycle(input logic v, input logic [1:0] d, input logic l, input logic r);
        drive(v, d, l, r);
        advance();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_dout_vld",  32'(dout_vld),  32'd0);
        chk("rst_din_rd",    32'(din_rd),    32'd0);
        chk("rst_dout_data", 32'(dout_data), 32'd0);
        chk("rst_dout_mask", 32'(dout_mask), 32'd0);
        chk("rst_dout_last", 32'(dout_last), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        held_q.delete();
        items.delete();
    endtask

    typedef struct {
        logic       v;
        logic [1:0] d;
        logic       l;
        logic       r;
        logic       e_vld;
        logic       e_rdy;
        logic [7:0] e_data;
        logic [3:0] e_mask;
        logic       e_last;
    } vec_t;

    vec_t tbl[10];
    int   w0;
    logic [7:0] snap_data;

    initial begin
        // Full word 1,2,3,0 then early-last word 3,2; expectations are the outputs seen
        // during each row's cycle, before its edge.
        tbl[0] = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 4'h0, 1'b0};
        tbl[1] = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 4'h1, 1'b0};
        tbl[2] = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 8'h09, 4'h3, 1'b0};
        tbl[3] = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h39, 4'h7, 1'b0};
        tbl[4] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h39, 4'hF, 1'b0};
        tbl[5] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 4'h0, 1'b0};
        tbl[6] = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 4'h0, 1'b0};
        tbl[7] = '{1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 8'h03, 4'h1, 1'b0};
        tbl[8] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h0B, 4'h3, 1'b1};
        tbl[9] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 4'h0, 1'b0};

        rst_n = 1'b0;
        din_vld = 1'b0; din_data = '0; din_last = 1'b0; dout_rd = 1'b0;
        p_din_vld = 1'b0; p_din_data = '0; p_din_last = 1'b0; p_dout_rd = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        // Table vectors; row 0 also shows a transfer on the first edge after reset.
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r);
            chk($sformatf("tbl%0d_dout_vld", i),  32'(dout_vld),  32'(tbl[i].e_vld));
            chk($sformatf("tbl%0d_din_rd", i),    32'(din_rd),    32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_dout_data", i), 32'(dout_data), 32'(tbl[i].e_data));
            chk($sformatf("tbl%0d_dout_mask", i), 32'(dout_mask), 32'(tbl[i].e_mask));
            chk($sformatf("tbl%0d_dout_last", i), 32'(dout_last), 32'(tbl[i].e_last));
            advance();
        end

        // Backpressure: hold a word for 5 cycles with din_vld high, then release it
        // together with a new item.
        cycle(1'b1, 2'd2, 1'b0, 1'b0);
        cycle(1'b1, 2'd1, 1'b0, 1'b0);
        cycle(1'b1, 2'd3, 1'b0, 1'b0);
        cycle(1'b1, 2'd1, 1'b0, 1'b0);
        snap_data = dout_data;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 2'd0, 1'b1, 1'b0);
            chk("bp_din_rd_low", 32'(din_rd), 32'd0);
            chk("bp_data_stable", 32'(dout_data), 32'(snap_data));
        end
        chk("bp_held_data", 32'(dout_data), 32'h76);
        cycle(1'b1, 2'd2, 1'b0, 1'b1);
        chk("bp_new_vld",  32'(dout_vld),  32'd0);
        chk("bp_new_mask", 32'(dout_mask), 32'h1);
        chk("bp_new_data", 32'(dout_data), 32'h2);
        do_reset();

        // Continuous stream of 12 items with the consumer always ready.
        w0 = words_out;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 2'(i), 1'b0, 1'b1);
            chk("stream_no_bubble", 32'(din_rd), 32'd1);
            advance();
        end
        cycle(1'b0, 2'd0, 1'b0, 1'b1);
        chk("stream_words", 32'(words_out - w0), 32'd3);

        // Reset after two items; the next four items must form a fresh word.
        cycle(1'b1, 2'd3, 1'b0, 1'b1);
        cycle(1'b1, 2'd3, 1'b0, 1'b1);
        do_reset();
        cycle(1'b1, 2'd2, 1'b0, 1'b1);
        cycle(1'b1, 2'd0, 1'b0, 1'b1);
        cycle(1'b1, 2'd1, 1'b0, 1'b1);
        cycle(1'b1, 2'd3, 1'b0, 1'b1);
        drive(1'b0, 2'd0, 1'b0, 1'b1);
        chk("rst_mid_vld",  32'(dout_vld),  32'd1);
        chk("rst_mid_data", 32'(dout_data), 32'hD2);
        chk("rst_mid_mask", 32'(dout_mask), 32'hF);
        advance();

        // Randomized traffic against the model, including simultaneous in/out transfers.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 2'd0, 1'b0, 1'b1);

        // DATA_WIDTH=3, ITEMS=2 instance: items 5 then 6.
        p_din_vld = 1'b1; p_din_data = 3'd5;
        @(posedge clk); #1;
        p_din_data = 3'd6;
        @(posedge clk); #1;
        p_din_vld = 1'b0;
        #1;
        chk("p_dout_vld",  32'(p_dout_vld),  32'd1);
        chk("p_dout_data", 32'(p_dout_data), 32'h35);
        chk("p_dout_mask", 32'(p_dout_mask), 32'h3);
        chk("p_dout_last", 32'(p_dout_last), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
